// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT BRAM stream adapter: default widths, FSM state encoding
// and the bit-reverse helper used when NTT_STREAM_BITREV_EN is defined.
package ntt_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Reverses the low nbits of v; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r = (r << 1) | ((v >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_stream_fifo.sv
// Small synchronous FIFO that buffers BRAM read data in front of the output stream.
// Depth need not be a power of two; pointers wrap explicitly.
module ntt_stream_fifo #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push & (r_count != CNT_FULL);
  assign w_do_pop  = i_pop & (r_count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ntt_bram_stream.sv
// Host-facing stream adapter on BRAM port B: loads N_COEFF words from s_* into BRAM, and
// streams them back out on m_*. Define NTT_STREAM_BITREV_EN for bit-reversed load addressing.
module ntt_bram_stream
  import ntt_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_COEFF   = 8192,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_load,
  input  logic              start_read,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              load_done,
  output logic              read_done,
  output logic [ADDR_W-1:0] BRAM_addr,
  output logic              BRAM_clk,
  output logic [DATA_W-1:0] BRAM_din,
  input  logic [DATA_W-1:0] BRAM_dout,
  output logic              BRAM_en,
  output logic              BRAM_we,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a word moves on any cycle where valid && ready are both high.
  // s_ready depends only on state; m_valid only on FIFO occupancy. Neither waits on the
  // other side's valid/ready, so no combinational loop can form through this block.

  localparam int IDX_W  = ADDR_W + 1;
  localparam int FIFO_D = RD_LAT + 2;
  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_COEFF - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  FIFO_CAP = CNT_W'(FIFO_D);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_widx;
  logic [IDX_W-1:0]  r_ridx;
  logic [IDX_W-1:0]  r_pidx;
  logic [RD_LAT-1:0] r_vld;
  logic              r_load_done;
  logic              r_read_done;

  logic              w_beat;
  logic              w_last_wr;
  logic              w_issue;
  logic              w_last_rd;
  logic              w_pop;
  logic              w_last_pop;
  logic              w_push;
  logic [ADDR_W-1:0] w_wr_off;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_inflight;
  logic [RD_LAT-1:0] w_vld_tmp;
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_fifo_empty;

`ifdef NTT_STREAM_BITREV_EN
  localparam int LOG2N = $clog2(N_COEFF);
  assign w_wr_off = ADDR_W'(bitrev(32'(r_widx), LOG2N));
`else
  assign w_wr_off = r_widx[ADDR_W-1:0];
`endif

  assign w_beat    = (r_state == ST_LOAD) & s_valid;
  assign w_last_wr = w_beat & (r_widx == LAST_IDX);

  // A read may issue only if every word already in flight still has a FIFO slot after it,
  // so the FIFO can never overflow regardless of how m_ready behaves.
  always_comb begin
    w_inflight = '0;
    w_vld_tmp  = r_vld;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CNT_W'(w_vld_tmp[0]);
      w_vld_tmp  = w_vld_tmp >> 1;
    end
  end

  assign w_free     = FIFO_CAP - w_count;
  assign w_issue    = (r_state == ST_READ) & (w_free > w_inflight);
  assign w_last_rd  = w_issue & (r_ridx == LAST_IDX);
  assign w_push     = r_vld[RD_LAT-1];
  assign m_valid    = ~w_fifo_empty;
  assign m_data     = w_fifo_data;
  assign w_pop      = m_valid & m_ready;
  assign w_last_pop = (r_state == ST_DRAIN) & w_pop & (r_pidx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    busy        = 1'b1;
    BRAM_en     = 1'b0;
    BRAM_we     = 1'b0;
    BRAM_din    = '0;
    BRAM_addr   = '0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_load)      w_state_nxt = ST_LOAD;
        else if (start_read) w_state_nxt = ST_READ;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (w_beat) begin
          BRAM_en   = 1'b1;
          BRAM_we   = 1'b1;
          BRAM_din  = s_data;
          BRAM_addr = BASE + w_wr_off;
        end
        if (w_last_wr) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (w_issue) begin
          BRAM_en   = 1'b1;
          BRAM_addr = BASE + r_ridx[ADDR_W-1:0];
        end
        if (w_last_rd) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_last_pop) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_widx      <= '0;
      r_ridx      <= '0;
      r_pidx      <= '0;
      r_vld       <= '0;
      r_load_done <= 1'b0;
      r_read_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_done <= w_last_wr;
      r_read_done <= w_last_pop;
      r_vld       <= (r_vld << 1) | RD_LAT'(w_issue);
      if (r_state == ST_IDLE) begin
        r_widx <= '0;
        r_ridx <= '0;
        r_pidx <= '0;
      end else begin
        if (w_beat)  r_widx <= r_widx + 1'b1;
        if (w_issue) r_ridx <= r_ridx + 1'b1;
        if (w_pop)   r_pidx <= r_pidx + 1'b1;
      end
    end
  end

  ntt_stream_fifo #(
    .DEPTH  (FIFO_D),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (BRAM_dout),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign load_done = r_load_done;
  assign read_done = r_read_done;
  assign BRAM_clk  = clk;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ntt_bram_stream.sv
// Bench for ntt_bram_stream: two instances (8192-word RD_LAT=2 at base 0, and 4-word
// RD_LAT=1 at base 8190) each on a behavioural BRAM, checked against a reference memory.
module tb_ntt_bram_stream;

`ifdef NTT_STREAM_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        start_load [2];
  logic        start_read [2];
  logic        s_valid    [2];
  logic        m_ready    [2];
  logic [63:0] s_data     [2];

  logic        a_s_ready, a_m_valid, a_busy, a_ld, a_rd, a_en, a_we, a_bclk;
  logic [63:0] a_m_data, a_din, a_dout;
  logic [12:0] a_addr;
  logic [1:0]  a_st;
  logic        b_s_ready, b_m_valid, b_busy, b_ld, b_rd, b_en, b_we, b_bclk;
  logic [63:0] b_m_data, b_din, b_dout;
  logic [12:0] b_addr;
  logic [1:0]  b_st;

  ntt_bram_stream #(.ADDR_W(13), .DATA_W(64), .N_COEFF(8192), .BASE_ADDR(0), .RD_LAT(2)) u_dut_a (
    .clk(clk), .rstn(rstn), .start_load(start_load[0]), .start_read(start_read[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(m_ready[0]),
    .busy(a_busy), .load_done(a_ld), .read_done(a_rd),
    .BRAM_addr(a_addr), .BRAM_clk(a_bclk), .BRAM_din(a_din), .BRAM_dout(a_dout),
    .BRAM_en(a_en), .BRAM_we(a_we), .dbg_state(a_st)
  );

  ntt_bram_stream #(.ADDR_W(13), .DATA_W(64), .N_COEFF(4), .BASE_ADDR(8190), .RD_LAT(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .start_load(start_load[1]), .start_read(start_read[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(m_ready[1]),
    .busy(b_busy), .load_done(b_ld), .read_done(b_rd),
    .BRAM_addr(b_addr), .BRAM_clk(b_bclk), .BRAM_din(b_din), .BRAM_dout(b_dout),
    .BRAM_en(b_en), .BRAM_we(b_we), .dbg_state(b_st)
  );

  // ---------------- behavioural BRAMs ----------------
  logic [63:0] mem_a [8192];
  logic [63:0] mem_b [8192];
  logic [63:0] pa0, pa1, pb0;

  always @(posedge clk) begin
    if (a_en && a_we)  mem_a[a_addr] <= a_din;
    if (a_en && !a_we) pa0 <= mem_a[a_addr];
    pa1 <= pa0;
  end
  assign a_dout = pa1;

  always @(posedge clk) begin
    if (b_en && b_we)  mem_b[b_addr] <= b_din;
    if (b_en && !b_we) pb0 <= mem_b[b_addr];
  end
  assign b_dout = pb0;

  // ---------------- monitors ----------------
  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t wlog_a[$];
  wr_t wlog_b[$];
  int  ld_cnt [2] = '{0, 0};
  int  rd_cnt [2] = '{0, 0};

  always @(posedge clk) begin
    if (a_en && a_we) wlog_a.push_back('{addr: a_addr, data: a_din});
    if (b_en && b_we) wlog_b.push_back('{addr: b_addr, data: b_din});
  end

  always @(negedge clk) begin
    if (a_ld) ld_cnt[0]++;
    if (b_ld) ld_cnt[1]++;
    if (a_rd) rd_cnt[0]++;
    if (b_rd) rd_cnt[1]++;
  end

  typedef struct {
    logic        s_ready, m_valid, busy, ld, rd, en, we;
    logic [1:0]  st;
    logic [12:0] addr;
    logic [63:0] din, m_data;
  } outs_t;

  function automatic outs_t get_o(input int d);
    outs_t x;
    if (d == 0) x = '{a_s_ready, a_m_valid, a_busy, a_ld, a_rd, a_en, a_we, a_st, a_addr, a_din, a_m_data};
    else        x = '{b_s_ready, b_m_valid, b_busy, b_ld, b_rd, b_en, b_we, b_st, b_addr, b_din, b_m_data};
    return x;
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] ref_m [2][8192];
  logic [63:0] exp_q[$];

  function automatic int base_of(input int d);
    return (d == 0) ? 0 : 8190;
  endfunction

  function automatic int n_of(input int d);
    return (d == 0) ? 8192 : 4;
  endfunction

  function automatic int rev_bits(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (((v >> i) & 1) != 0) r += (1 << (bits - 1 - i));
    return r;
  endfunction

  // Where write number k of an n-word load lands in BRAM.
  function automatic int addr_of(input int d, input int k);
    int off = BITREV ? rev_bits(k, $clog2(n_of(d))) : k;
    return (base_of(d) + off) % 8192;
  endfunction

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input int d, input string tag);
    outs_t x = get_o(d);
    chk({tag, "_ctl"}, 64'({x.s_ready, x.m_valid, x.busy, x.ld, x.rd, x.en, x.we, x.st, x.addr}), 64'd0);
    chk({tag, "_din"}, x.din, 64'd0);
    chk({tag, "_mdata"}, x.m_data, 64'd0);
  endtask

  // ---------------- drivers ----------------
  // mode 0: data=k, 1: data=0xB000+k, 2: random
  task automatic load(input int d, input int vpct, input int mode, input bit both, output int cyc);
    int k, n, lbase, ld0;
    logic [63:0] sd[$];
    n     = n_of(d);
    lbase = (d == 0) ? wlog_a.size() : wlog_b.size();
    ld0   = ld_cnt[d];
    start_load[d] = 1'b1;
    start_read[d] = both;
    tick();
    start_load[d] = 1'b0;
    start_read[d] = 1'b0;
    if (both) begin
      @(negedge clk);
      chk("both_start_state", 64'(get_o(d).st), 64'd1);
      chk("both_start_sready", 64'(get_o(d).s_ready), 64'd1);
      tick();
    end
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 20000) begin
      s_valid[d]    = ($urandom_range(0, 99) < vpct);
      s_data[d]     = (mode == 0) ? 64'(k) : (mode == 1) ? 64'hB000 + 64'(k) : {$urandom, $urandom};
      start_read[d] = both && (cyc == 1);
      @(negedge clk);
      if (s_valid[d] && get_o(d).s_ready) begin
        ref_m[d][addr_of(d, k)] = s_data[d];
        sd.push_back(s_data[d]);
        k++;
      end
      tick();
      cyc++;
    end
    s_valid[d]    = 1'b0;
    start_read[d] = 1'b0;
    chk("load_beats", 64'(k), 64'(n));
    @(negedge clk);
    chk("load_done_pulse", 64'(get_o(d).ld), 64'd1);
    chk("load_idle", 64'(get_o(d).busy), 64'd0);
    tick();
    @(negedge clk);
    chk("load_done_once", 64'(ld_cnt[d] - ld0), 64'd1);
    chk("load_wr_count", 64'(((d == 0) ? wlog_a.size() : wlog_b.size()) - lbase), 64'(n));
    for (int j = 0; j < n && j < sd.size(); j++) begin
      wr_t w = (d == 0) ? wlog_a[lbase + j] : wlog_b[lbase + j];
      if (w.addr !== 13'(addr_of(d, j)) || w.data !== sd[j])
        chk("load_wr_entry", {w.data[50:0], w.addr}, {sd[j][50:0], 13'(addr_of(d, j))});
    end
    tick();
  endtask

  task automatic read(input int d, input int rpct, input int abort_at, output int cyc);
    int got, n, rd0;
    n   = n_of(d);
    rd0 = rd_cnt[d];
    exp_q.delete();
    for (int j = 0; j < n; j++) exp_q.push_back(ref_m[d][(base_of(d) + j) % 8192]);
    start_read[d] = 1'b1;
    tick();
    start_read[d] = 1'b0;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 40000) begin
      m_ready[d] = ($urandom_range(0, 99) < rpct);
      @(negedge clk);
      if (get_o(d).m_valid && m_ready[d]) begin
        logic [63:0] e = exp_q.pop_front();
        if (get_o(d).m_data !== e) chk("read_word", get_o(d).m_data, e);
        else checks++;
        got++;
      end
      if (abort_at >= 0 && got == abort_at) begin
        rstn = 1'b0;
        #1;
        chk_quiet(d, "midreset");
        tick();
        tick();
        rstn       = 1'b1;
        m_ready[d] = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("abort_no_read_done", 64'(rd_cnt[d] - rd0), 64'd0);
        chk("abort_idle", 64'(get_o(d).busy), 64'd0);
        tick();
        exp_q.delete();
        return;
      end
      tick();
      cyc++;
    end
    m_ready[d] = 1'b0;
    chk("read_words", 64'(got), 64'(n));
    chk("read_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("read_done_pulse", 64'(get_o(d).rd), 64'd1);
    chk("read_idle", 64'(get_o(d).busy), 64'd0);
    tick();
    @(negedge clk);
    chk("read_done_once", 64'(rd_cnt[d] - rd0), 64'd1);
    chk("read_mvalid_low", 64'(get_o(d).m_valid), 64'd0);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          d;
    int          k;
    logic [12:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vt[8];

  initial begin
    int cyc;
    vt[0] = '{0, 0,    13'd0,    64'd0};
    vt[1] = '{0, 8191, 13'd8191, 64'd8191};
    vt[4] = '{1, 0,    13'd8190, 64'hB000};
    vt[7] = '{1, 3,    13'd1,    64'hB003};
    if (BITREV) begin
      vt[2] = '{0, 1, 13'd4096, 64'd1};
      vt[3] = '{0, 3, 13'd6144, 64'd3};
      vt[5] = '{1, 1, 13'd0,    64'hB001};
      vt[6] = '{1, 2, 13'd8191, 64'hB002};
    end else begin
      vt[2] = '{0, 1, 13'd1,    64'd1};
      vt[3] = '{0, 3, 13'd3,    64'd3};
      vt[5] = '{1, 1, 13'd8191, 64'hB001};
      vt[6] = '{1, 2, 13'd0,    64'hB002};
    end

    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_load[d] = 1'b0;
      start_read[d] = 1'b0;
      s_valid[d]    = 1'b0;
      m_ready[d]    = 1'b0;
      s_data[d]     = 64'hDEAD_BEEF_0000_0000 + 64'(d);
    end
    repeat (3) @(negedge clk);
    chk_quiet(0, "reset_a");
    chk_quiet(1, "reset_b");
    chk("bram_clk_a", 64'(a_bclk), 64'(clk));
    chk("bram_clk_b", 64'(b_bclk), 64'(clk));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();

    // Simultaneous starts prefer LOAD; start_read during LOAD is ignored; address wrap.
    load(1, 100, 1, 1'b1, cyc);
    read(1, 50, -1, cyc);

    // Full 8192-word load at one word per cycle.
    load(0, 100, 0, 1'b0, cyc);
    chk("load_throughput", 64'(cyc), 64'd8192);

    for (int i = 0; i < 8; i++) begin
      wr_t w;
      if (vt[i].d == 0) w = (vt[i].k < wlog_a.size()) ? wlog_a[vt[i].k] : '{13'h1FFF, 64'hX};
      else              w = (vt[i].k < wlog_b.size()) ? wlog_b[vt[i].k] : '{13'h1FFF, 64'hX};
      chk($sformatf("vec%0d_addr", i), 64'(w.addr), 64'(vt[i].exp_addr));
      chk($sformatf("vec%0d_data", i), w.data, vt[i].exp_data);
    end

    // Read-back under random backpressure.
    read(0, 50, -1, cyc);

    // Reset at word 100 abandons the read; a later full-rate read is complete and in order.
    read(0, 100, 100, cyc);
    chk_quiet(1, "after_reset_b");
    read(0, 100, -1, cyc);
    chk("read_throughput", 64'(cyc <= 8192 + 6), 64'd1);

    // Randomized data, s_valid gaps and m_ready patterns on the short instance.
    for (int r = 0; r < 6; r++) begin
      load(1, 60, 2, 1'b0, cyc);
      read(1, $urandom_range(20, 90), -1, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
